mux_pipe_scan: RTL
==================

// Module: mux_pipe_scan
// PURPOSE
//  Parametrised, pipelined N:1 multiplexer of WIDTH-bit channels.
//  - Built as a tree of registered 4:1 stages.
//  - Select comes from the sel port (manual) or an internal round-robin scan counter (auto-scan).
//  - Each result carries its channel tag and a valid flag.
//  - Successor to the combinational 16:1 structural mux; drives channel scanners and serialisers downstream.
// PARAMETERS
//  WIDTH  1   bits per channel, >=1
//  NCH    16  channel count; power of 4, >=4 (4, 16, 64, ...)
//  SELW   4   select width; must equal log2(NCH)
//  (derived localparam LEVELS = SELW/2 = number of pipeline stages = latency)
// PORTS
//  clk        in   1           rising-edge clock, sole clock
//  rst        in   1           synchronous, active-high reset
//  in         in   NCH*WIDTH   channel k occupies in[k*WIDTH +: WIDTH]
//  sel        in   SELW        channel select, used when mode=0
//  mode       in   1           0 = manual select, 1 = auto-scan
//  in_valid   in   1           qualifies in/sel this cycle
//  out        out  WIDTH       selected channel data
//  out_sel    out  SELW        channel tag belonging to out
//  out_valid  out  1           out/out_sel valid
//  scan_wrap  out  1           with out_valid; marks tag NCH-1 produced in auto-scan
// BEHAVIOUR
//  - One clock. Reset is synchronous and active-high.
//  - Reset: out=0, out_sel=0, out_valid=0, scan_wrap=0, scan_cnt=0, all stage regs and valids=0.
//  - Reset mid-operation flushes the pipe: out_valid stays 0 until LEVELS cycles after the first in_valid following reset.
//  - Effective select: esel = mode ? scan_cnt : sel, sampled with in on an in_valid cycle.
//  - Stage s (0..LEVELS-1) resolves esel bits [2s+1:2s] through 4:1 muxes; every stage output is registered.
//  - Latency is exactly LEVELS cycles. Throughput is 1 result per cycle with no stalls; there is no backpressure.
//  - Tag, mode flag and valid travel alongside the data.
//  - A stage's valid register loads every cycle.
//  - A stage's data and tag registers load only when the incoming valid=1; on bubbles they hold.
//  - So out/out_sel hold their last value while out_valid=0.
//  - scan_cnt advances by 1 on each cycle with mode=1 and in_valid=1, wrapping NCH-1 -> 0.
//  - scan_cnt holds when in_valid=0 or mode=0.
//  - A rising edge of mode (registered mode_q=0, mode=1) forces esel=0 that cycle, and scan_cnt becomes 1 if in_valid=1, else 0.
//  - scan_wrap = out_valid & tag==NCH-1 & result issued in auto-scan. It is never asserted for manual selects.
//  - Changing sel or mode mid-pipe does not affect results already in flight.
//  - Arithmetic: scan_cnt is SELW bits; natural overflow gives the wrap.
// STRUCTURE
//  - Shared header mux_pipe_defs.vh holds:
//    - the log2/levels helper function,
//    - the parameter legality check (NCH power of 4, SELW == log2(NCH)),
//    - the reset-value constants.
//  - Sub-module mux4_stage holds one registered WIDTH-bit 4:1 mux with load enable.
//  - Generate loops instantiate NCH/4^(s+1) copies of mux4_stage at level s.
//  - The scan counter and the tag/valid pipeline live in the top level.
// TESTING
//  1. WIDTH=1, NCH=16, mode=0, in=16'h3f0a, sel=0,1,6,12 on consecutive valid cycles
//     -> 2 cycles later out=0,1,0,1, out_sel=0,1,6,12, out_valid=1 each cycle.
//  2. Same in, mode=1, in_valid=1 for 16 cycles
//     -> out=0,1,0,1,0,0,0,0,1,1,1,1,1,1,0,0 with tags 0..15.
//     -> scan_wrap=1 only on tag 15; a 17th valid cycle returns tag 0.
//  3. WIDTH=8, NCH=4, in={8'hd4,8'hc3,8'hb2,8'ha1}, sel=2
//     -> next cycle out=8'hc3, out_sel=2, out_valid=1 (LEVELS=1).
//  4. Bubbles: mode=1, in_valid pattern 1,0,1
//     -> out_valid 1,0,1 with tags 0,-,1; out holds during the bubble; scan_cnt does not advance.
//  5. Assert rst for 1 cycle while 2 results are in flight
//     -> out_valid=0, out=0, scan_wrap=0 next cycle.
//     -> after release, first valid output appears LEVELS cycles after first in_valid; scan restarts at tag 0.
//  6. Toggle mode 0->1 mid-stream with sel=9 in flight
//     -> tag 9 emerges unchanged, then auto-scan tags 0,1,2...

Source files
------------

// File: rtl/mux_pipe_scan_pkg.sv
// Shared definitions for the pipelined scan multiplexer.
//   - select-mode encoding
//   - reset values for the control flops
//   - elaboration-time helpers: exact log2, pipeline depth, parameter legality
package mux_pipe_scan_pkg;

    typedef enum logic {
        SEL_MANUAL = 1'b0,
        SEL_AUTO   = 1'b1
    } sel_mode_e;

    localparam logic RST_VALID = 1'b0;
    localparam logic RST_MODE  = 1'b0;

    // Exact base-2 log; -1 when n is not a power of two.
    function automatic int log2_exact(input int n);
        int res;
        res = -1;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) == n) res = i;
        end
        return res;
    endfunction

    // Each registered stage resolves two select bits.
    function automatic int levels_of(input int selw);
        return selw / 2;
    endfunction

    // WIDTH >= 1, NCH a power of 4 (>= 4), SELW == log2(NCH).
    function automatic bit params_legal(input int width, input int nch, input int selw);
        int lg;
        lg = log2_exact(nch);
        return (width >= 1) && (nch >= 4) && (lg > 0) && (lg % 2 == 0) && (selw == lg);
    endfunction

endpackage

// File: rtl/mux_pipe_scan_mux4_stage.sv
// One registered WIDTH-bit 4:1 mux with load enable.
//   clk, rst : clock, synchronous active-high reset
//   load     : capture the selected channel this cycle, otherwise hold
//   sel      : 2-bit channel select within this group of four
//   din      : four channels, channel k at din[k*WIDTH +: WIDTH]
//   dout     : registered result
module mux_pipe_scan_mux4_stage #(
    parameter int WIDTH = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [1:0]         sel,
    input  logic [4*WIDTH-1:0] din,
    output logic [WIDTH-1:0]   dout
);

    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        // NOTE: default to the held value first so no path leaves data_d unassigned (no latch).
        data_d = data_q;
        if (load) begin
            data_d = din[sel*WIDTH +: WIDTH];
        end
    end

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) data_q <= '0;
        else     data_q <= data_d;
    end

    assign dout = data_q;

endmodule

// File: rtl/mux_pipe_scan.sv
// Pipelined N:1 multiplexer of WIDTH-bit channels built from registered 4:1 stages.
// Select comes from sel (manual) or an internal round-robin scan counter (auto-scan).
//   clk, rst  : clock, synchronous active-high reset
//   in        : NCH channels, channel k at in[k*WIDTH +: WIDTH]
//   sel       : manual channel select (mode=0)
//   mode      : 0 manual, 1 auto-scan
//   in_valid  : qualifies in/sel this cycle
//   out       : selected data, LEVELS cycles after the input
//   out_sel   : channel tag of out
//   out_valid : out/out_sel valid
//   scan_wrap : valid auto-scan result carrying tag NCH-1
module mux_pipe_scan
    import mux_pipe_scan_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int NCH   = 16,
    parameter int SELW  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    input  logic                 in_valid,
    output logic [WIDTH-1:0]     out,
    output logic [SELW-1:0]      out_sel,
    output logic                 out_valid,
    output logic                 scan_wrap
);

    localparam int LEVELS = levels_of(SELW);

    if (!params_legal(WIDTH, NCH, SELW)) begin : g_bad_params
        $error("mux_pipe_scan: NCH must be a power of 4 and SELW == log2(NCH)");
    end

    // ---------------- select front end ----------------
    logic            mode_d, mode_q;
    logic            mode_rise;
    logic [SELW-1:0] scan_cnt_d, scan_cnt_q;
    logic [SELW-1:0] esel;

    always_comb begin
        mode_d     = mode;
        mode_rise  = (mode == SEL_AUTO) && (mode_q == SEL_MANUAL);
        scan_cnt_d = scan_cnt_q;
        esel       = sel;
        if (mode == SEL_AUTO) begin
            if (mode_rise) begin
                // Entering auto-scan always starts from channel 0.
                esel       = '0;
                scan_cnt_d = in_valid ? SELW'(1) : '0;
            end else begin
                esel = scan_cnt_q;
                if (in_valid) scan_cnt_d = scan_cnt_q + 1'b1;
            end
        end
    end

    // ---------------- tag / mode / valid pipeline ----------------
    logic [LEVELS-1:0][SELW-1:0] tag_d, tag_q;
    logic [LEVELS-1:0]           auto_d, auto_q;
    logic [LEVELS-1:0]           valid_d, valid_q;

    always_comb begin
        valid_d[0] = in_valid;
        tag_d[0]   = in_valid ? esel : tag_q[0];
        auto_d[0]  = in_valid ? mode : auto_q[0];
        for (int s = 1; s < LEVELS; s++) begin
            valid_d[s] = valid_q[s-1];
            tag_d[s]   = valid_q[s-1] ? tag_q[s-1]  : tag_q[s];
            auto_d[s]  = valid_q[s-1] ? auto_q[s-1] : auto_q[s];
        end
    end

    // NOTE: every pipeline register, data included, is cleared by reset so no stale result can leak out.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= RST_MODE;
            scan_cnt_q <= '0;
            valid_q    <= {LEVELS{RST_VALID}};
            tag_q      <= '0;
            auto_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            scan_cnt_q <= scan_cnt_d;
            valid_q    <= valid_d;
            tag_q      <= tag_d;
            auto_q     <= auto_d;
        end
    end

    // ---------------- data tree ----------------
    // Level s holds NCH/4^(s+1) muxes and resolves select bits [2s+1:2s].
    for (genvar s = 0; s < LEVELS; s++) begin : g_lvl
        localparam int N_OUT = NCH >> (2 * (s + 1));

        logic [4*N_OUT*WIDTH-1:0] din;
        logic [N_OUT*WIDTH-1:0]   dout;
        logic [1:0]               lsel;
        logic                     load;

        if (s == 0) begin : g_first
            assign din  = in;
            assign lsel = esel[1:0];
            assign load = in_valid;
        end else begin : g_next
            // The tag registered beside the previous level steers this one.
            assign din  = g_lvl[s-1].dout;
            assign lsel = tag_q[s-1][2*s +: 2];
            assign load = valid_q[s-1];
        end

        for (genvar k = 0; k < N_OUT; k++) begin : g_mux
            mux_pipe_scan_mux4_stage #(
                .WIDTH(WIDTH)
            ) u_mux (
                .clk  (clk),
                .rst  (rst),
                .load (load),
                .sel  (lsel),
                .din  (din[k*4*WIDTH +: 4*WIDTH]),
                .dout (dout[k*WIDTH +: WIDTH])
            );
        end
    end

    assign out       = g_lvl[LEVELS-1].dout;
    assign out_sel   = tag_q[LEVELS-1];
    assign out_valid = valid_q[LEVELS-1];
    assign scan_wrap = valid_q[LEVELS-1] && (auto_q[LEVELS-1] == SEL_AUTO)
                       && (tag_q[LEVELS-1] == SELW'(NCH - 1));

endmodule
